// File: rtl/vc_router_if.sv
// rtl/vc_router_if.sv - ingress, VC FIFO write and telemetry signals of vc_router
interface vc_router_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] main_data;
    logic              main_empty;
    logic              main_pop;
    logic              VC0_pause;
    logic              VC1_pause;
    logic [DATA_W-1:0] VC0_data;
    logic              VC0_push;
    logic [DATA_W-1:0] VC1_data;
    logic              VC1_push;
    logic [CNT_W-1:0]  vc0_count;
    logic [CNT_W-1:0]  vc1_count;
    logic [CNT_W-1:0]  stall_count;
    logic [1:0]        state;

    // master drives the ingress FIFO head and pause flags; slave is the router
    modport master (
        output main_data, main_empty, VC0_pause, VC1_pause,
        input  main_pop, VC0_data, VC0_push, VC1_data, VC1_push,
        input  vc0_count, vc1_count, stall_count, state
    );

    modport slave (
        input  main_data, main_empty, VC0_pause, VC1_pause,
        output main_pop, VC0_data, VC0_push, VC1_data, VC1_push,
        output vc0_count, vc1_count, stall_count, state
    );
endinterface

// File: rtl/vc_router.sv
// rtl/vc_router.sv - steers main FIFO words into VC0/VC1 by class bit with head-of-line blocking
module vc_router #(
    parameter int DATA_W = 6,
    parameter int VC_BIT = 5,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    vc_router_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] vc0_data_q, vc0_data_d;
    logic [DATA_W-1:0] vc1_data_q, vc1_data_d;
    logic              vc0_push_q, vc0_push_d;
    logic              vc1_push_q, vc1_push_d;
    logic [CNT_W-1:0]  vc0_count_q, vc0_count_d;
    logic [CNT_W-1:0]  vc1_count_q, vc1_count_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              tgt;
    logic              tgt_pause;
    logic              pop;

    always_comb begin
        tgt       = bus.main_data[VC_BIT];
        tgt_pause = tgt ? bus.VC1_pause : bus.VC0_pause;
        // only the head word's target matters, so a paused VC blocks everything behind it
        pop       = !reset && !bus.main_empty && !tgt_pause;

        vc0_data_d    = vc0_data_q;
        vc1_data_d    = vc1_data_q;
        vc0_push_d    = 1'b0;
        vc1_push_d    = 1'b0;
        vc0_count_d   = vc0_count_q;
        vc1_count_d   = vc1_count_q;
        stall_count_d = stall_count_q;

        if (pop) begin
            if (tgt) begin
                vc1_data_d  = bus.main_data;
                vc1_push_d  = 1'b1;
                vc1_count_d = vc1_count_q + CNT_W'(1);
            end else begin
                vc0_data_d  = bus.main_data;
                vc0_push_d  = 1'b1;
                vc0_count_d = vc0_count_q + CNT_W'(1);
            end
        end

        if (bus.main_empty) begin
            state_d = IDLE;
        end else if (pop) begin
            state_d = ROUTE;
        end else begin
            state_d = STALL;
        end

        if (state_d == STALL && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            vc0_data_q    <= '0;
            vc1_data_q    <= '0;
            vc0_push_q    <= 1'b0;
            vc1_push_q    <= 1'b0;
            vc0_count_q   <= '0;
            vc1_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            vc0_data_q    <= vc0_data_d;
            vc1_data_q    <= vc1_data_d;
            vc0_push_q    <= vc0_push_d;
            vc1_push_q    <= vc1_push_d;
            vc0_count_q   <= vc0_count_d;
            vc1_count_q   <= vc1_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.main_pop    = pop;
    assign bus.VC0_data    = vc0_data_q;
    assign bus.VC0_push    = vc0_push_q;
    assign bus.VC1_data    = vc1_data_q;
    assign bus.VC1_push    = vc1_push_q;
    assign bus.vc0_count   = vc0_count_q;
    assign bus.vc1_count   = vc1_count_q;
    assign bus.stall_count = stall_count_q;
    assign bus.state       = state_q;
endmodule
